multicycle_ctrl_unit: RTL and testbench
=======================================

Name: multicycle_ctrl_unit

Overview:
Parametrised successor to the multicycle MIPS control FSM. It adds addi, bne, illegal-opcode trapping, an explicit idle/reset state and a debug state output. It sits between the instruction register and the multicycle datapath (PC, memory, register file, ALU muxes), and drives all datapath enables and mux selects as Moore outputs of a 4-bit state register.

Parameters:
OPW, 6, opcode width
ALUOPW, 2, ALUop width (encodings: 0 add, 1 sub, 2 funct-decoded; upper bits zero)
RTYPE_OP, 6'd0, R-type opcode
LW_OP, 6'd35, load word opcode
SW_OP, 6'd43, store word opcode
BEQ_OP, 6'd4, branch-equal opcode
BNE_OP, 6'd5, branch-not-equal opcode
J_OP, 6'd2, jump opcode
ADDI_OP, 6'd8, add-immediate opcode

Ports:
clk  in  1  clock, rising edge
Reset  in  1  asynchronous, active-high reset
opcode  in  OPW  IR[31:26], valid from DECODE onward
RegDst  out  1  write reg = rd (1) / rt (0)
RegWrite  out  1  register file write enable
PCWriteCond  out  1  PC write if branch condition holds
PCWrite  out  1  unconditional PC write
BranchNe  out  1  invert Zero for the branch condition (bne)
IorD  out  1  memory address = ALUOut (1) / PC (0)
MemRead  out  1  memory read strobe
MemWrite  out  1  memory write strobe
MemtoReg  out  1  write data = MDR (1) / ALUOut (0)
IRWrite  out  1  instruction register load
ALUSrcA  out  1  A operand = reg A (1) / PC (0)
PCSource  out  2  0 ALU result, 1 ALUOut, 2 jump target
ALUSrcB  out  2  0 reg B, 1 const 4, 2 signext imm, 3 signext imm<<2
ALUop  out  ALUOPW  ALU operation class
IllegalOp  out  1  one-cycle pulse on an unknown opcode
state_o  out  4  current state, for debug

Behaviour:
- Async Reset forces state = IDLE. All outputs in IDLE are 0, so every output resets to 0.
- State updates on the rising clk edge. Outputs are combinational functions of state only (Moore). The opcode is sampled into opreg at the end of DECODE, and all later decisions use opreg.
- States, their nonzero outputs, and the next state:
  - IDLE(0): all outputs 0 -> FETCH.
  - FETCH(1): MemRead, IRWrite, PCWrite, ALUSrcB=1 -> DECODE.
  - DECODE(2): ALUSrcB=3. Next state depends on opcode:
    - lw/sw -> MEMADR
    - R-type -> REXE
    - beq/bne -> BRANCH
    - addi -> ADDIEX
    - j -> JUMP
    - anything else -> ILLEGAL
  - MEMADR(3): ALUSrcA, ALUSrcB=2 -> MEMRD if lw, MEMWR if sw.
  - MEMRD(4): MemRead, IorD -> MEMWB.
  - MEMWB(5): RegWrite, MemtoReg -> FETCH.
  - MEMWR(6): MemWrite, IorD -> FETCH.
  - REXE(7): ALUSrcA, ALUop=2 -> RWB.
  - RWB(8): RegWrite, RegDst -> FETCH.
  - BRANCH(9): ALUSrcA, ALUop=1, PCWriteCond, PCSource=1; BranchNe=1 only if opreg==BNE_OP -> FETCH.
  - ADDIEX(10): ALUSrcA, ALUSrcB=2, ALUop=0 -> ADDIWB.
  - ADDIWB(11): RegWrite (RegDst=0, MemtoReg=0) -> FETCH.
  - JUMP(12): PCWrite, PCSource=2 -> FETCH.
  - ILLEGAL(13): IllegalOp=1 -> FETCH. The instruction is skipped and the PC was already advanced.
- Unused encodings 14 and 15 -> IDLE, with all outputs 0.
- Cycles per instruction:
  - lw 5
  - sw, R-type, addi 4
  - beq, bne, j, illegal 3
- Opcode parameters must be distinct. An opcode change during execute states has no effect (opreg is held).
- Reset asserted mid-instruction aborts it immediately. Outputs go to 0 in the same time step, with no clock needed.
- ALUop values are zero-extended to ALUOPW.

Optional Feature:
MEM_WAIT_EN.
- Defined: adds input MemReady (1 bit). FETCH, MEMRD and MEMWR hold their state and outputs while MemReady=0, and advance when MemReady=1. While held, PCWrite and IRWrite are asserted only in the cycle where MemReady=1, so the PC cannot double-increment.
- Undefined: the port is absent and every memory state takes exactly one cycle. This is identical to MemReady tied to 1.

Decomposition:
- Package multicycle_ctrl_pkg holds:
  - the state typedef and the 14 state constants
  - ALUop constants (ALU_ADD, ALU_SUB, ALU_FUNCT)
  - PCSource constants (PCS_ALU, PCS_ALUOUT, PCS_JUMP)
  - ALUSrcB constants (SRCB_REG, SRCB_FOUR, SRCB_IMM, SRCB_IMMSH)
- One sub-module is natural: multicycle_ctrl_decode, a purely combinational map from state and opreg to outputs. The top level keeps the state register, opreg and the next-state logic.

Test Plan:
- Reset=1 at t=1, released at t=4 -> all outputs 0, state_o=0. One edge later state_o=1 with MemRead=IRWrite=PCWrite=1 and ALUSrcB=1.
- opcode=35 (lw) -> state sequence 1,2,3,4,5,1. At state 5, RegWrite=MemtoReg=1. Lasts 5 cycles.
- opcode=5 (bne) -> sequence 1,2,9,1. In state 9, PCWriteCond=1, BranchNe=1, PCSource=1, ALUop=1. Repeat with opcode=4 -> BranchNe=0.
- opcode=8 (addi), then opcode changed to 0 in state 10 -> path stays 10,11. In state 11, RegWrite=1 and RegDst=0.
- opcode=6'h3F -> sequence 1,2,13,1, with IllegalOp high for exactly one cycle.
- MEM_WAIT_EN, lw with MemReady=0 for 3 cycles in MEMRD -> state_o stays 4 for 4 cycles, then advances to 5.
- Reset pulsed while in MEMWR -> MemWrite drops immediately, state_o=0.

Source files
------------

// File: rtl/multicycle_ctrl_pkg.sv
// Shared types and encodings for the multicycle control unit: state codes,
// ALUop classes, PCSource and ALUSrcB mux selects.
package multicycle_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_FETCH   = 4'd1,
    S_DECODE  = 4'd2,
    S_MEMADR  = 4'd3,
    S_MEMRD   = 4'd4,
    S_MEMWB   = 4'd5,
    S_MEMWR   = 4'd6,
    S_REXE    = 4'd7,
    S_RWB     = 4'd8,
    S_BRANCH  = 4'd9,
    S_ADDIEX  = 4'd10,
    S_ADDIWB  = 4'd11,
    S_JUMP    = 4'd12,
    S_ILLEGAL = 4'd13
  } state_e;

  localparam logic [1:0] ALU_ADD   = 2'd0;
  localparam logic [1:0] ALU_SUB   = 2'd1;
  localparam logic [1:0] ALU_FUNCT = 2'd2;

  localparam logic [1:0] PCS_ALU    = 2'd0;
  localparam logic [1:0] PCS_ALUOUT = 2'd1;
  localparam logic [1:0] PCS_JUMP   = 2'd2;

  localparam logic [1:0] SRCB_REG   = 2'd0;
  localparam logic [1:0] SRCB_FOUR  = 2'd1;
  localparam logic [1:0] SRCB_IMM   = 2'd2;
  localparam logic [1:0] SRCB_IMMSH = 2'd3;

endpackage

// File: rtl/multicycle_ctrl_decode.sv
// Combinational map from the current state (plus latched opcode and memory
// ready) to every datapath enable and mux select.
module multicycle_ctrl_decode
  import multicycle_ctrl_pkg::*;
#(
  parameter int             OPW    = 6,
  parameter int             ALUOPW = 2,
  parameter logic [OPW-1:0] BNE_OP = 6'd5
) (
  input  state_e            state_i,
  input  logic [OPW-1:0]    opreg_i,
  input  logic              mem_ready_i,
  output logic              RegDst,
  output logic              RegWrite,
  output logic              PCWriteCond,
  output logic              PCWrite,
  output logic              BranchNe,
  output logic              IorD,
  output logic              MemRead,
  output logic              MemWrite,
  output logic              MemtoReg,
  output logic              IRWrite,
  output logic              ALUSrcA,
  output logic [1:0]        PCSource,
  output logic [1:0]        ALUSrcB,
  output logic [ALUOPW-1:0] ALUop,
  output logic              IllegalOp
);

  always_comb begin
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    PCWriteCond = 1'b0;
    PCWrite     = 1'b0;
    BranchNe    = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    MemtoReg    = 1'b0;
    IRWrite     = 1'b0;
    ALUSrcA     = 1'b0;
    PCSource    = PCS_ALU;
    ALUSrcB     = SRCB_REG;
    ALUop       = ALUOPW'(ALU_ADD);
    IllegalOp   = 1'b0;
    case (state_i)
      S_FETCH: begin
        // PC/IR load only on the accepted cycle so a stalled fetch cannot double-increment
        MemRead  = 1'b1;
        IRWrite  = mem_ready_i;
        PCWrite  = mem_ready_i;
        PCSource = PCS_ALU;
        ALUSrcB  = SRCB_FOUR;
      end
      S_DECODE: ALUSrcB = SRCB_IMMSH;
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      S_MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      S_REXE: begin
        ALUSrcA = 1'b1;
        ALUop   = ALUOPW'(ALU_FUNCT);
      end
      S_RWB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUop       = ALUOPW'(ALU_SUB);
        PCWriteCond = 1'b1;
        PCSource    = PCS_ALUOUT;
        BranchNe    = (opreg_i == BNE_OP);
      end
      S_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        ALUop   = ALUOPW'(ALU_ADD);
      end
      S_ADDIWB: RegWrite = 1'b1;
      S_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = PCS_JUMP;
      end
      S_ILLEGAL: IllegalOp = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl_unit.sv
// Multicycle MIPS control FSM with addi/bne/illegal-op trap and debug state.
// Optional MEM_WAIT_EN adds MemReady to stall FETCH/MEMRD/MEMWR.
//   state   | meaning
//   IDLE    | reset, outputs quiet
//   FETCH   | read instr, PC += 4
//   DECODE  | read regs, branch target, latch opcode
//   MEMADR  | lw/sw address
//   MEMRD   | data read
//   MEMWB   | load writeback
//   MEMWR   | data write
//   REXE    | R-type ALU
//   RWB     | R-type writeback
//   BRANCH  | beq/bne compare + PC
//   ADDIEX  | addi ALU
//   ADDIWB  | addi writeback
//   JUMP    | PC = jump target
//   ILLEGAL | IllegalOp pulse, skip instr
module multicycle_ctrl_unit
  import multicycle_ctrl_pkg::*;
#(
  parameter int             OPW      = 6,
  parameter int             ALUOPW   = 2,
  parameter logic [OPW-1:0] RTYPE_OP = 6'd0,
  parameter logic [OPW-1:0] LW_OP    = 6'd35,
  parameter logic [OPW-1:0] SW_OP    = 6'd43,
  parameter logic [OPW-1:0] BEQ_OP   = 6'd4,
  parameter logic [OPW-1:0] BNE_OP   = 6'd5,
  parameter logic [OPW-1:0] J_OP     = 6'd2,
  parameter logic [OPW-1:0] ADDI_OP  = 6'd8
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic [OPW-1:0]    opcode,
`ifdef MEM_WAIT_EN
  input  logic              MemReady,
`endif
  output logic              RegDst,
  output logic              RegWrite,
  output logic              PCWriteCond,
  output logic              PCWrite,
  output logic              BranchNe,
  output logic              IorD,
  output logic              MemRead,
  output logic              MemWrite,
  output logic              MemtoReg,
  output logic              IRWrite,
  output logic              ALUSrcA,
  output logic [1:0]        PCSource,
  output logic [1:0]        ALUSrcB,
  output logic [ALUOPW-1:0] ALUop,
  output logic              IllegalOp,
  output logic [3:0]        state_o
);

  state_e         state_q, state_d;
  logic [OPW-1:0] opreg_q, opreg_d;
  logic           mem_ready;

`ifdef MEM_WAIT_EN
  assign mem_ready = MemReady;
`else
  assign mem_ready = 1'b1;
`endif

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state_q <= S_IDLE;
      opreg_q <= '0;
    end else begin
      state_q <= state_d;
      opreg_q <= opreg_d;
    end
  end

  always_comb begin
    state_d = state_q;
    opreg_d = opreg_q;
    case (state_q)
      S_IDLE:  state_d = S_FETCH;
      S_FETCH: if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        // dispatch on the live opcode; everything after uses the latched copy
        opreg_d = opcode;
        if (opcode == LW_OP || opcode == SW_OP)        state_d = S_MEMADR;
        else if (opcode == RTYPE_OP)                   state_d = S_REXE;
        else if (opcode == BEQ_OP || opcode == BNE_OP) state_d = S_BRANCH;
        else if (opcode == ADDI_OP)                    state_d = S_ADDIEX;
        else if (opcode == J_OP)                       state_d = S_JUMP;
        else                                           state_d = S_ILLEGAL;
      end
      S_MEMADR:  state_d = (opreg_q == LW_OP) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   if (mem_ready) state_d = S_MEMWB;
      S_MEMWB:   state_d = S_FETCH;
      S_MEMWR:   if (mem_ready) state_d = S_FETCH;
      S_REXE:    state_d = S_RWB;
      S_RWB:     state_d = S_FETCH;
      S_BRANCH:  state_d = S_FETCH;
      S_ADDIEX:  state_d = S_ADDIWB;
      S_ADDIWB:  state_d = S_FETCH;
      S_JUMP:    state_d = S_FETCH;
      S_ILLEGAL: state_d = S_FETCH;
      default:   state_d = S_IDLE;
    endcase
  end

  assign state_o = state_q;

  multicycle_ctrl_decode #(
    .OPW    (OPW),
    .ALUOPW (ALUOPW),
    .BNE_OP (BNE_OP)
  ) u_decode (
    .state_i     (state_q),
    .opreg_i     (opreg_q),
    .mem_ready_i (mem_ready),
    .RegDst      (RegDst),
    .RegWrite    (RegWrite),
    .PCWriteCond (PCWriteCond),
    .PCWrite     (PCWrite),
    .BranchNe    (BranchNe),
    .IorD        (IorD),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .MemtoReg    (MemtoReg),
    .IRWrite     (IRWrite),
    .ALUSrcA     (ALUSrcA),
    .PCSource    (PCSource),
    .ALUSrcB     (ALUSrcB),
    .ALUop       (ALUop),
    .IllegalOp   (IllegalOp)
  );

endmodule

// File: tb/tb_multicycle_ctrl_unit.sv
// Directed bench for multicycle_ctrl_unit: per-instruction vector table plus
// hand sequences for reset, mid-instruction reset and (MEM_WAIT_EN) stalls.
module tb_multicycle_ctrl_unit;

  typedef struct packed {
    logic       reg_dst, reg_write, pc_write_cond, pc_write, branch_ne, iord;
    logic       mem_read, mem_write, memto_reg, ir_write, alu_src_a;
    logic [1:0] pc_source, alu_src_b, alu_op;
    logic       illegal_op;
  } outs_t;

  typedef struct {
    logic [5:0] op;
    logic [5:0] op_late;
    int         len;
    int         seq [5];
    logic       bne;
  } vec_t;

  logic       clk, Reset;
  logic [5:0] opcode;
  logic       MemReady;
  logic       RegDst, RegWrite, PCWriteCond, PCWrite, BranchNe, IorD;
  logic       MemRead, MemWrite, MemtoReg, IRWrite, ALUSrcA, IllegalOp;
  logic [1:0] PCSource, ALUSrcB, ALUop;
  logic [3:0] state_o;

  int tests = 0;
  int fails = 0;

  outs_t exp_out [16];
  vec_t  tbl [10];

  multicycle_ctrl_unit dut (
    .clk         (clk),
    .Reset       (Reset),
    .opcode      (opcode),
`ifdef MEM_WAIT_EN
    .MemReady    (MemReady),
`endif
    .RegDst      (RegDst),
    .RegWrite    (RegWrite),
    .PCWriteCond (PCWriteCond),
    .PCWrite     (PCWrite),
    .BranchNe    (BranchNe),
    .IorD        (IorD),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .MemtoReg    (MemtoReg),
    .IRWrite     (IRWrite),
    .ALUSrcA     (ALUSrcA),
    .PCSource    (PCSource),
    .ALUSrcB     (ALUSrcB),
    .ALUop       (ALUop),
    .IllegalOp   (IllegalOp),
    .state_o     (state_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic outs_t cur_outs();
    outs_t o;
    o.reg_dst       = RegDst;
    o.reg_write     = RegWrite;
    o.pc_write_cond = PCWriteCond;
    o.pc_write      = PCWrite;
    o.branch_ne     = BranchNe;
    o.iord          = IorD;
    o.mem_read      = MemRead;
    o.mem_write     = MemWrite;
    o.memto_reg     = MemtoReg;
    o.ir_write      = IRWrite;
    o.alu_src_a     = ALUSrcA;
    o.pc_source     = PCSource;
    o.alu_src_b     = ALUSrcB;
    o.alu_op        = ALUop;
    o.illegal_op    = IllegalOp;
    return o;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    outs_t e;
    for (int i = 0; i < 16; i++) exp_out[i] = '0;
    exp_out[1].mem_read = 1; exp_out[1].ir_write = 1; exp_out[1].pc_write = 1;
    exp_out[1].alu_src_b = 2'd1;
    exp_out[2].alu_src_b = 2'd3;
    exp_out[3].alu_src_a = 1; exp_out[3].alu_src_b = 2'd2;
    exp_out[4].mem_read = 1; exp_out[4].iord = 1;
    exp_out[5].reg_write = 1; exp_out[5].memto_reg = 1;
    exp_out[6].mem_write = 1; exp_out[6].iord = 1;
    exp_out[7].alu_src_a = 1; exp_out[7].alu_op = 2'd2;
    exp_out[8].reg_write = 1; exp_out[8].reg_dst = 1;
    exp_out[9].alu_src_a = 1; exp_out[9].alu_op = 2'd1;
    exp_out[9].pc_write_cond = 1; exp_out[9].pc_source = 2'd1;
    exp_out[10].alu_src_a = 1; exp_out[10].alu_src_b = 2'd2;
    exp_out[11].reg_write = 1;
    exp_out[12].pc_write = 1; exp_out[12].pc_source = 2'd2;
    exp_out[13].illegal_op = 1;

    tbl[0] = '{6'd35, 6'd35, 5, '{1, 2, 3, 4, 5},  1'b0};  // lw
    tbl[1] = '{6'd43, 6'd43, 4, '{1, 2, 3, 6, 0},  1'b0};  // sw
    tbl[2] = '{6'd0,  6'd0,  4, '{1, 2, 7, 8, 0},  1'b0};  // R-type
    tbl[3] = '{6'd5,  6'd5,  3, '{1, 2, 9, 0, 0},  1'b1};  // bne
    tbl[4] = '{6'd4,  6'd4,  3, '{1, 2, 9, 0, 0},  1'b0};  // beq
    tbl[5] = '{6'd8,  6'd0,  4, '{1, 2, 10, 11, 0}, 1'b0}; // addi, opcode -> 0 late
    tbl[6] = '{6'd2,  6'd2,  3, '{1, 2, 12, 0, 0}, 1'b0};  // j
    tbl[7] = '{6'h3F, 6'h3F, 3, '{1, 2, 13, 0, 0}, 1'b0};  // illegal
    tbl[8] = '{6'd35, 6'd43, 5, '{1, 2, 3, 4, 5},  1'b0};  // lw, opcode -> sw late
    tbl[9] = '{6'd1,  6'd1,  3, '{1, 2, 13, 0, 0}, 1'b0};  // illegal

    Reset    = 1'b0;
    opcode   = 6'd0;
    MemReady = 1'b1;
    #1 Reset = 1'b1;
    #1;
    chk("reset_state_during", int'(state_o), 0);
    chk("reset_outs_during", int'(cur_outs()), 0);
    #2 Reset = 1'b0;
    chk("reset_state_after", int'(state_o), 0);
    chk("reset_outs_after", int'(cur_outs()), 0);
    step();
    chk("first_fetch_state", int'(state_o), 1);
    chk("first_fetch_outs", int'(cur_outs()), int'(exp_out[1]));

    for (int v = 0; v < 10; v++) begin
      opcode = tbl[v].op;
      for (int k = 0; k < tbl[v].len; k++) begin
        if (k == 2) opcode = tbl[v].op_late;
        e = exp_out[tbl[v].seq[k]];
        if (tbl[v].seq[k] == 9) e.branch_ne = tbl[v].bne;
        chk($sformatf("v%0d_state_c%0d", v, k), int'(state_o), tbl[v].seq[k]);
        chk($sformatf("v%0d_outs_c%0d", v, k), int'(cur_outs()), int'(e));
        step();
      end
      chk($sformatf("v%0d_return_state", v), int'(state_o), 1);
      chk($sformatf("v%0d_return_outs", v), int'(cur_outs()), int'(exp_out[1]));
    end

`ifdef MEM_WAIT_EN
    opcode   = 6'd35;
    MemReady = 1'b0;
    e = exp_out[1];
    e.pc_write = 0;
    e.ir_write = 0;
    chk("wait_fetch_outs", int'(cur_outs()), int'(e));
    step();
    chk("wait_fetch_hold", int'(state_o), 1);
    MemReady = 1'b1;
    chk("wait_fetch_release_outs", int'(cur_outs()), int'(exp_out[1]));
    step();
    chk("wait_decode", int'(state_o), 2);
    step();
    chk("wait_memadr", int'(state_o), 3);
    step();
    MemReady = 1'b0;
    chk("wait_memrd_c0", int'(state_o), 4);
    for (int i = 1; i < 4; i++) begin
      step();
      chk($sformatf("wait_memrd_c%0d", i), int'(state_o), 4);
      chk($sformatf("wait_memrd_outs_c%0d", i), int'(cur_outs()), int'(exp_out[4]));
    end
    MemReady = 1'b1;
    step();
    chk("wait_memwb", int'(state_o), 5);
    step();
    chk("wait_back_fetch", int'(state_o), 1);
`endif

    opcode = 6'd43;
    step();
    step();
    step();
    chk("midrst_memwr_state", int'(state_o), 6);
    chk("midrst_memwr_we", int'(MemWrite), 1);
    #2 Reset = 1'b1;
    #1;
    chk("midrst_we_dropped", int'(MemWrite), 0);
    chk("midrst_state", int'(state_o), 0);
    chk("midrst_outs", int'(cur_outs()), 0);
    #2 Reset = 1'b0;
    step();
    chk("midrst_refetch", int'(state_o), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
